seg7_scan_display: RTL and testbench

//   Parametrised multiplexed seven-segment driver for the board display path. Scans NUM_DIGITS

---
 rtl/seg7_scan_display.sv | 131 +++++++++++++
 tb/tb_seg7_scan_display.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment scanner: hex decode, dp, per-digit blanking, PWM dimming and
// an anode guard band; new content is accepted into a pending buffer and committed at frame wrap.
module seg7_scan_display #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned DUTY_BITS  = 4,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [4*NUM_DIGITS-1:0]   upd_value,
    input  logic [NUM_DIGITS-1:0]     upd_dp,
    input  logic [NUM_DIGITS-1:0]     upd_blank,
    input  logic [DUTY_BITS-1:0]      brightness,
    output logic                      frame_start,
    output logic [NUM_DIGITS-1:0]     digi_an,
    output logic [7:0]                digi_seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam logic        INV   = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [DUTY_BITS-1:0]  pwm_cnt;
    logic                  pending;
    logic [VAL_W-1:0]      pend_value, act_value;
    logic [NUM_DIGITS-1:0] pend_dp, act_dp;
    logic [NUM_DIGITS-1:0] pend_blank, act_blank;

    logic                  wrap_slot, wrap_frame, accept, commit, pending_nxt;
    logic                  pwm_on, lit;
    logic [3:0]            nibble;
    logic [6:0]            pat;
    logic [NUM_DIGITS-1:0] an_act;
    logic [7:0]            seg_act;

    // Scan timing and update handshake decisions
    always_comb begin
        wrap_slot   = (div_cnt == DIV_W'(SCAN_DIV - 1));
        wrap_frame  = wrap_slot && (idx == IDX_W'(NUM_DIGITS - 1));
        accept      = upd_valid && upd_ready;
        commit      = wrap_frame && pending;
        pending_nxt = pending;
        if (commit)
            pending_nxt = 1'b0;
        else if (accept)
            pending_nxt = 1'b1;
    end

    // Hex decode, active-high {g..a}
    always_comb begin
        nibble = act_value[{idx, 2'b00} +: 4];
        pat    = 7'h00;
        case (nibble)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
    end

    // Lit decision; everything dark outside the lit window
    always_comb begin
        pwm_on  = (brightness == {DUTY_BITS{1'b1}}) || (pwm_cnt < brightness);
        lit     = pwm_on && (div_cnt >= DIV_W'(GUARD)) && !act_blank[idx];
        an_act  = '0;
        seg_act = 8'h00;
        if (lit) begin
            an_act[idx] = 1'b1;
            seg_act     = {act_dp[idx], pat};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            pending     <= 1'b0;
            pend_value  <= '0;
            pend_dp     <= '0;
            pend_blank  <= '1;
            act_value   <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            upd_ready   <= 1'b1;
            frame_start <= 1'b0;
            digi_an     <= {NUM_DIGITS{INV}};
            digi_seg    <= {8{INV}};
        end else begin
            pwm_cnt     <= pwm_cnt + DUTY_BITS'(1);
            div_cnt     <= wrap_slot ? '0 : div_cnt + DIV_W'(1);
            if (wrap_slot)
                idx <= wrap_frame ? '0 : idx + IDX_W'(1);
            frame_start <= wrap_frame;
            pending     <= pending_nxt;
            upd_ready   <= !pending_nxt;
            if (accept) begin
                pend_value <= upd_value;
                pend_dp    <= upd_dp;
                pend_blank <= upd_blank;
            end
            if (commit) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            digi_an  <= an_act ^ {NUM_DIGITS{INV}};
            digi_seg <= seg_act ^ {8{INV}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: table of per-slot expectations plus hand sequences
// for reset, commit timing, stalled update, dimming and mid-frame reset.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_value;
    logic [3:0]  upd_dp;
    logic [3:0]  upd_blank;
    logic [3:0]  brightness;
    logic        frame_start;
    logic [3:0]  digi_an;
    logic [7:0]  digi_seg;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_display #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .DUTY_BITS(4), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_value(upd_value), .upd_dp(upd_dp), .upd_blank(upd_blank),
        .brightness(brightness), .frame_start(frame_start),
        .digi_an(digi_an), .digi_seg(digi_seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
        int          digit;
        int          offs;
        logic [3:0]  exp_an;
        logic [7:0]  exp_seg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to the cycle where frame_start is high (bounded)
    task automatic wait_frame(input string name);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (frame_start) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: frame_start timeout at %0t", name, $time);
        end
    endtask

    task automatic wait_ready(input string name);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (upd_ready) begin
                seen = 1;
                break;
            end
            step(1);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: upd_ready timeout at %0t", name, $time);
        end
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        wait_ready("send");
        upd_value = v;
        upd_dp    = dp;
        upd_blank = bl;
        upd_valid = 1'b1;
        step(1);
        upd_valid = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        bit ok;
        rst        = 1'b1;
        upd_valid  = 1'b0;
        upd_value  = '0;
        upd_dp     = '0;
        upd_blank  = '0;
        brightness = 4'hF;

        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'hF, 0, 2, 4'hE, 8'h99});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'hF, 3, 7, 4'h7, 8'hF9});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'hF, 1, 0, 4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'hF, 2, 1, 4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'hF, 1, 4, 4'hD, 8'hB0});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'hF, 2, 5, 4'hB, 8'hA4});
        vecs.push_back('{16'hABCD, 4'h0, 4'h0, 4'hF, 0, 3, 4'hE, 8'hA1});
        vecs.push_back('{16'hABCD, 4'h0, 4'h0, 4'hF, 3, 2, 4'h7, 8'h88});
        vecs.push_back('{16'hEF09, 4'h0, 4'h0, 4'hF, 0, 6, 4'hE, 8'h90});
        vecs.push_back('{16'hEF09, 4'h0, 4'h0, 4'hF, 1, 6, 4'hD, 8'hC0});
        vecs.push_back('{16'hEF09, 4'h0, 4'h0, 4'hF, 2, 6, 4'hB, 8'h8E});
        vecs.push_back('{16'hEF09, 4'h0, 4'h0, 4'hF, 3, 6, 4'h7, 8'h86});
        vecs.push_back('{16'h1234, 4'h1, 4'h4, 4'hF, 2, 4, 4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'h1, 4'h4, 4'hF, 0, 4, 4'hE, 8'h19});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'h8, 0, 3, 4'hE, 8'h99});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'h8, 1, 3, 4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'h8, 2, 7, 4'hB, 8'hA4});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'h8, 3, 2, 4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'h0, 0, 4, 4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'h0, 4'h0, 4'h1, 2, 2, 4'hF, 8'hFF});

        // Reset state
        #12;
        check("reset_an", 32'(digi_an), 32'h0000000F);
        check("reset_seg", 32'(digi_seg), 32'h000000FF);
        check("reset_ready", 32'(upd_ready), 32'h1);
        check("reset_frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Nothing lights before the first commit
        ok = 1;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (digi_an !== 4'hF) ok = 0;
        end
        check("dark_before_commit", 32'(ok), 32'h1);

        // Mid-frame update: ready low until frame_start, then guard then lit
        wait_frame("commit_sync");
        step(10);
        send(16'h1234, 4'h0, 4'h0);
        check("ready_low_after_accept", 32'(upd_ready), 32'h0);
        ok = 1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (frame_start) break;
            if (upd_ready !== 1'b0) ok = 0;
        end
        check("ready_held_low_until_frame", 32'(ok), 32'h1);
        check("frame_start_seen", 32'(frame_start), 32'h1);
        check("ready_at_frame_start", 32'(upd_ready), 32'h1);
        step(1);
        check("frame_start_one_cycle", 32'(frame_start), 32'h0);
        check("guard_k0_an", 32'(digi_an), 32'hF);
        step(1);
        check("guard_k1_an", 32'(digi_an), 32'hF);
        step(1);
        check("first_lit_an", 32'(digi_an), 32'hE);
        check("first_lit_seg", 32'(digi_seg), 32'h99);

        // Table: each vector committed, then one slot/offset sampled
        foreach (vecs[n]) begin
            brightness = vecs[n].bright;
            send(vecs[n].value, vecs[n].dp, vecs[n].blank);
            wait_frame("vec_frame");
            step(1 + 8 * vecs[n].digit + vecs[n].offs);
            check($sformatf("vec%0d_an", n), 32'(digi_an), 32'(vecs[n].exp_an));
            check($sformatf("vec%0d_seg", n), 32'(digi_seg), 32'(vecs[n].exp_seg));
        end

        // Stall: second request held off until the cycle after commit
        brightness = 4'hF;
        send(16'h1234, 4'h0, 4'h0);
        upd_value = 16'h8888;
        upd_dp    = 4'h0;
        upd_blank = 4'h0;
        upd_valid = 1'b1;
        step(1);
        check("stall_ready_low", 32'(upd_ready), 32'h0);
        wait_frame("stall_frame");
        check("stall_ready_at_commit", 32'(upd_ready), 32'h1);
        step(1);
        upd_valid = 1'b0;
        check("stall_accepted", 32'(upd_ready), 32'h0);
        step(2);
        check("stall_old_an", 32'(digi_an), 32'hE);
        check("stall_old_seg", 32'(digi_seg), 32'h99);
        step(29);
        check("stall_old_last_slot_seg", 32'(digi_seg), 32'hF9);
        check("stall_next_frame_start", 32'(frame_start), 32'h1);
        step(3);
        check("stall_new_an", 32'(digi_an), 32'hE);
        check("stall_new_seg", 32'(digi_seg), 32'h80);

        // Brightness 0: dark for 64 cycles
        brightness = 4'h0;
        ok = 1;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (digi_an !== 4'hF) ok = 0;
        end
        check("bright0_dark", 32'(ok), 32'h1);
        brightness = 4'hF;

        // Reset during digit-2 slot with an update pending
        wait_frame("rst_frame");
        send(16'h5555, 4'h0, 4'h0);
        step(19);
        check("pre_rst_an", 32'(digi_an), 32'hB);
        check("pre_rst_pending", 32'(upd_ready), 32'h0);
        rst = 1'b1;
        #1;
        check("rst_async_an", 32'(digi_an), 32'hF);
        check("rst_async_seg", 32'(digi_seg), 32'hFF);
        check("rst_async_ready", 32'(upd_ready), 32'h1);
        step(2);
        rst = 1'b0;
        ok = 1;
        for (int i = 0; i < 70; i++) begin
            step(1);
            if (digi_an !== 4'hF || digi_seg !== 8'hFF) ok = 0;
        end
        check("post_rst_dark", 32'(ok), 32'h1);
        check("post_rst_ready", 32'(upd_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
